// File: rtl/fir_sample_feeder_if.sv
// Sample-feeder control/data bundle: memory write port,
// run control in, filter-side sample stream out.
interface fir_sample_feeder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              loop_en;
    logic              stall;
    logic [DATA_W-1:0] x_n;
    logic              x_valid;
    logic [ADDR_W-1:0] sample_idx;
    logic              busy;
    logic              done;

    modport master (
        output wr_en, wr_addr, wr_data,
        output start, loop_en, stall,
        input  x_n, x_valid, sample_idx,
        input  busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  start, loop_en, stall,
        output x_n, x_valid, sample_idx,
        output busy, done
    );
endinterface

// File: rtl/fir_sample_feeder.sv
// Streams a preloaded sample memory into the FIR x_n input,
// one sample per clock, with stall, loop and done pulse.
module fir_sample_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input logic              clk,
    input logic              rstn,
    fir_sample_feeder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    state_t            state;
    logic [ADDR_W-1:0] rd_addr;

    // Sample memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Run FSM with registered stream outputs; a same-cycle
    // write to rd_addr is not seen here (old data wins).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            rd_addr        <= '0;
            bus.x_n        <= '0;
            bus.x_valid    <= 1'b0;
            bus.sample_idx <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.x_n     <= '0;
                    bus.x_valid <= 1'b0;
                    bus.done    <= 1'b0;
                    bus.busy    <= 1'b0;
                    if (bus.start) begin
                        state    <= RUN;
                        rd_addr  <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        bus.x_n        <= mem[rd_addr];
                        bus.x_valid    <= 1'b1;
                        bus.sample_idx <= rd_addr;
                        rd_addr        <= rd_addr + 1'b1;
                        if (rd_addr == LAST && !bus.loop_en) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    bus.x_n     <= '0;
                    bus.x_valid <= 1'b0;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state       <= IDLE;
                    bus.x_n     <= '0;
                    bus.x_valid <= 1'b0;
                    bus.done    <= 1'b0;
                    bus.busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: reset, full run,
// stall, loop with write hazard, mid-run reset, ignored start.
module tb_fir_sample_feeder;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    fir_sample_feeder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    fir_sample_feeder #(.DATA_W(8), .DEPTH(256), .ADDR_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < 256; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 8'(i);
            bus.wr_data = 8'(i);
            step();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic kick();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_chk++;
        if ({bus.x_n, bus.x_valid, bus.sample_idx, bus.busy, bus.done} !== 19'd0)
            $display("FAIL reset_outputs x_n=%h v=%b idx=%h busy=%b done=%b want all 0",
                     bus.x_n, bus.x_valid, bus.sample_idx, bus.busy, bus.done);
        else n_pass++;
        #5 rstn = 1'b1;
        step();
        preload_ramp();
        n_chk++;
        if (bus.busy !== 1'b0 || bus.x_valid !== 1'b0)
            $display("FAIL idle_after_preload busy=%b v=%b want 0 0", bus.busy, bus.x_valid);
        else n_pass++;
    endtask

    task automatic test_full_run();
        kick();
        n_chk++;
        if (bus.busy !== 1'b1 || bus.x_valid !== 1'b0)
            $display("FAIL run_latency busy=%b v=%b want 1 0", bus.busy, bus.x_valid);
        else n_pass++;
        for (int c = 1; c <= 256; c++) begin
            step();
            n_chk++;
            if (bus.x_valid !== 1'b1 || bus.x_n !== 8'(c - 1) ||
                bus.sample_idx !== 8'(c - 1) || bus.done !== 1'b0 ||
                bus.busy !== (c != 256))
                $display("FAIL run_sample c=%0d x_n=%h v=%b idx=%h busy=%b done=%b want x_n=%h",
                         c, bus.x_n, bus.x_valid, bus.sample_idx, bus.busy,
                         bus.done, 8'(c - 1));
            else n_pass++;
        end
        step();
        n_chk++;
        if (bus.done !== 1'b1 || bus.x_valid !== 1'b0 || bus.x_n !== 8'h00 || bus.busy !== 1'b0)
            $display("FAIL run_done done=%b v=%b x_n=%h busy=%b want 1 0 00 0",
                     bus.done, bus.x_valid, bus.x_n, bus.busy);
        else n_pass++;
        step();
        n_chk++;
        if (bus.done !== 1'b0 || bus.x_n !== 8'h00)
            $display("FAIL run_after_done done=%b x_n=%h want 0 00", bus.done, bus.x_n);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] exp;
        kick();
        for (int c = 1; c <= 259; c++) begin
            step();
            if (c <= 17) exp = 8'(c - 1);
            else if (c <= 20) exp = 8'h10;
            else exp = 8'(c - 4);
            n_chk++;
            if (bus.x_valid !== 1'b1 || bus.x_n !== exp || bus.done !== 1'b0)
                $display("FAIL stall_sample c=%0d x_n=%h v=%b done=%b want %h",
                         c, bus.x_n, bus.x_valid, bus.done, exp);
            else n_pass++;
            bus.stall = (c >= 17 && c <= 19);
        end
        step();
        n_chk++;
        if (bus.done !== 1'b1 || bus.x_valid !== 1'b0)
            $display("FAIL stall_done done=%b v=%b want 1 0", bus.done, bus.x_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_loop_write_hazard();
        logic [7:0] exp;
        bus.loop_en = 1'b1;
        kick();
        for (int c = 1; c <= 512; c++) begin
            step();
            exp = 8'((c - 1) % 256);
            if (c > 21 && exp == 8'd20) exp = 8'hA5;
            n_chk++;
            if (bus.x_valid !== 1'b1 || bus.x_n !== exp || bus.done !== 1'b0)
                $display("FAIL loop_sample c=%0d x_n=%h v=%b done=%b want %h",
                         c, bus.x_n, bus.x_valid, bus.done, exp);
            else n_pass++;
            bus.wr_en   = (c == 20);
            bus.wr_addr = 8'd20;
            bus.wr_data = 8'hA5;
            if (c == 300) bus.loop_en = 1'b0;
        end
        step();
        n_chk++;
        if (bus.done !== 1'b1 || bus.x_valid !== 1'b0)
            $display("FAIL loop_done done=%b v=%b want 1 0", bus.done, bus.x_valid);
        else n_pass++;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'd20;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        kick();
        for (int c = 1; c <= 101; c++) step();
        n_chk++;
        if (bus.x_n !== 8'd100 || bus.x_valid !== 1'b1)
            $display("FAIL mid_before x_n=%h v=%b want 64 1", bus.x_n, bus.x_valid);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_chk++;
        if ({bus.x_n, bus.x_valid, bus.sample_idx, bus.busy, bus.done} !== 19'd0)
            $display("FAIL mid_async x_n=%h v=%b idx=%h busy=%b done=%b want all 0",
                     bus.x_n, bus.x_valid, bus.sample_idx, bus.busy, bus.done);
        else n_pass++;
        step();
        step();
        #2 rstn = 1'b1;
        step();
        n_chk++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL mid_no_done done=%b busy=%b want 0 0", bus.done, bus.busy);
        else n_pass++;
        kick();
        for (int c = 1; c <= 3; c++) begin
            step();
            n_chk++;
            if (bus.x_n !== 8'(c - 1) || bus.x_valid !== 1'b1)
                $display("FAIL mid_replay c=%0d x_n=%h v=%b want %h", c,
                         bus.x_n, bus.x_valid, 8'(c - 1));
            else n_pass++;
        end
        for (int c = 0; c < 300 && bus.done !== 1'b1; c++) step();
        n_chk++;
        if (bus.done !== 1'b1)
            $display("FAIL mid_replay_done done=%b want 1 (timeout)", bus.done);
        else n_pass++;
        step();
    endtask

    task automatic test_start_ignored();
        int n_valid = 0;
        int n_done = 0;
        kick();
        for (int c = 1; c <= 262; c++) begin
            step();
            if (bus.x_valid === 1'b1) n_valid++;
            if (bus.done === 1'b1) n_done++;
            bus.start = (c == 50 || c == 256);
        end
        n_chk++;
        if (n_valid !== 256)
            $display("FAIL ignore_valid_count got=%0d want 256", n_valid);
        else n_pass++;
        n_chk++;
        if (n_done !== 1)
            $display("FAIL ignore_done_count got=%0d want 1", n_done);
        else n_pass++;
        n_chk++;
        if (bus.busy !== 1'b0)
            $display("FAIL ignore_no_restart busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.loop_en = 1'b0;
        bus.stall   = 1'b0;
        test_reset();
        test_full_run();
        test_stall();
        test_loop_write_hazard();
        test_reset_mid_run();
        test_start_ignored();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
